// File: rtl/board_move_detector.sv
// Debounces a 32-square occupancy bitmap and turns settled lift/place/capture
// sequences into move records handed off with a valid/ready handshake.
module board_move_detector #(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int SETTLE_CYCLES   = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] sensor_data,
  input  logic        resync,
  input  logic        move_ready,
  output logic        move_valid,
  output logic [4:0]  move_from,
  output logic [4:0]  move_to,
  output logic        move_capture,
  output logic [4:0]  capture_sq,
  output logic [31:0] committed_board,
  output logic        error
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {INIT, IDLE, LIFTED, SETTLE, EMIT, ERROR} state_t;

  state_t        state;
  logic [31:0]   sample;
  logic [31:0]   stable;
  logic [DW-1:0] dcnt;
  logic [SW-1:0] scnt;
  logic          stable_seen;
  logic          stable_chg;
  logic [31:0]   diff_clr;
  logic [31:0]   diff_set;
  logic [31:0]   rem_clr;

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

  function automatic logic [4:0] low_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int unsigned i = 32; i > 0; i--) begin
      if (v[i-1]) idx = 5'(i - 1);
    end
    return idx;
  endfunction

  always_comb begin
    diff_clr = committed_board & ~stable;
    diff_set = stable & ~committed_board;
    rem_clr  = diff_clr & ~(32'd1 << move_from);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= INIT;
      sample          <= '0;
      stable          <= '0;
      dcnt            <= '0;
      scnt            <= '0;
      stable_seen     <= 1'b0;
      stable_chg      <= 1'b0;
      move_valid      <= 1'b0;
      move_from       <= '0;
      move_to         <= '0;
      move_capture    <= 1'b0;
      capture_sq      <= '0;
      committed_board <= '0;
      error           <= 1'b0;
    end else begin
      sample     <= sensor_data;
      stable_chg <= 1'b0;
      if (sensor_data != sample) dcnt <= '0;
      else if (dcnt != DB_LAST) dcnt <= dcnt + DW'(1);
      // stable is reloaded every saturated cycle; stable_chg marks real changes only
      if (dcnt == DB_LAST) begin
        stable      <= sample;
        stable_seen <= 1'b1;
        stable_chg  <= (sample != stable);
      end

      if (resync && (state != INIT || stable_seen)) begin
        committed_board <= stable;
        move_valid      <= 1'b0;
        error           <= 1'b0;
        state           <= IDLE;
      end else begin
        case (state)
          INIT: begin
            if (stable_seen) begin
              committed_board <= stable;
              state           <= IDLE;
            end
          end
          IDLE: begin
            if (stable != committed_board) begin
              if (diff_set == '0 && is_onehot(diff_clr)) begin
                move_from <= low_idx(diff_clr);
                state     <= LIFTED;
              end else begin
                error <= 1'b1;
                state <= ERROR;
              end
            end
          end
          LIFTED: begin
            if (stable == committed_board) begin
              state <= IDLE;
            end else if (is_onehot(diff_set) && diff_clr[move_from]) begin
              move_to <= low_idx(diff_set);
              scnt    <= '0;
              state   <= SETTLE;
            end else if (diff_set != '0) begin
              error <= 1'b1;
              state <= ERROR;
            end
          end
          SETTLE: begin
            if (!is_onehot(diff_set)) begin
              error <= 1'b1;
              state <= ERROR;
            end else if (stable_chg) begin
              scnt <= '0;
            end else if (scnt == ST_LAST) begin
              if (rem_clr == '0) begin
                move_capture <= 1'b0;
                capture_sq   <= '0;
                move_valid   <= 1'b1;
                state        <= EMIT;
              end else if (is_onehot(rem_clr)) begin
                move_capture <= 1'b1;
                capture_sq   <= low_idx(rem_clr);
                move_valid   <= 1'b1;
                state        <= EMIT;
              end else begin
                error <= 1'b1;
                state <= ERROR;
              end
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
          EMIT: begin
            if (move_ready) begin
              committed_board <= stable;
              move_valid      <= 1'b0;
              state           <= IDLE;
            end
          end
          ERROR: begin
            if (stable == committed_board) begin
              error <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_move_detector.sv
// Bench for board_move_detector: directed scenarios plus random legal and
// illegal moves, checked against a board-level model of the move rules.
module tb_board_move_detector;

  localparam int DB = 4;
  localparam int ST = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sensor_data;
  logic        resync;
  logic        move_ready;
  logic        move_valid;
  logic [4:0]  move_from;
  logic [4:0]  move_to;
  logic        move_capture;
  logic [4:0]  capture_sq;
  logic [31:0] committed_board;
  logic        error;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_board;

  always #5 clk = ~clk;

  board_move_detector #(.DEBOUNCE_CYCLES(DB), .SETTLE_CYCLES(ST)) dut (
    .clk(clk), .reset(reset), .sensor_data(sensor_data), .resync(resync),
    .move_ready(move_ready), .move_valid(move_valid), .move_from(move_from),
    .move_to(move_to), .move_capture(move_capture), .capture_sq(capture_sq),
    .committed_board(committed_board), .error(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!move_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(move_valid), 32'd1);
  endtask

  function automatic int pick(input logic [31:0] b, input logic v);
    int i;
    do i = int'($urandom_range(31, 0)); while (b[i] != v);
    return i;
  endfunction

  // Drives lift, place and optional capture from model_board, then checks the record.
  task automatic play_move(input int f, input int t, input bit cap, input int c,
                           output logic [31:0] after);
    logic [31:0] b;
    b = model_board;
    b[f] = 1'b0;
    sensor_data = b;
    wait_cycles(10);
    check("lift_quiet", {30'd0, move_valid, error}, 32'd0);
    b[t] = 1'b1;
    sensor_data = b;
    if (cap) begin
      wait_cycles(6);
      b[c] = 1'b0;
      sensor_data = b;
    end
    wait_valid("move_valid");
    check("move_from", 32'(move_from), 32'(f));
    check("move_to", 32'(move_to), 32'(t));
    check("move_capture", 32'(move_capture), 32'(cap));
    check("capture_sq", 32'(capture_sq), cap ? 32'(c) : 32'd0);
    check("no_error", 32'(error), 32'd0);
    after = b;
  endtask

  task automatic handshake(input logic [31:0] exp_board);
    move_ready = 1'b1;
    @(negedge clk);
    move_ready = 1'b0;
    check("valid_drop", 32'(move_valid), 32'd0);
    check("committed", committed_board, exp_board);
    model_board = exp_board;
  endtask

  task automatic do_resync(input logic [31:0] b);
    sensor_data = b;
    wait_cycles(12);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    check("resync_board", committed_board, b);
    check("resync_err", 32'(error), 32'd0);
    model_board = b;
  endtask

  initial begin
    logic [31:0] after;
    logic [31:0] b;
    logic [16:0] fields;
    int f, t, c, a2;
    bit cap;

    reset = 1'b1; resync = 1'b0; move_ready = 1'b0; sensor_data = 32'h0000_0FFF;
    wait_cycles(3);
    check("rst_committed", committed_board, 32'd0);
    check("rst_fields", {15'd0, move_valid, move_from, move_to, move_capture, capture_sq},
          32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("pre_stable", committed_board, 32'd0);
    wait_cycles(10);
    check("init_board", committed_board, 32'h0000_0FFF);
    check("init_quiet", {30'd0, move_valid, error}, 32'd0);
    model_board = 32'h0000_0FFF;

    play_move(9, 13, 1'b0, 0, after);
    handshake(32'h0000_2DFF);

    sensor_data = model_board & ~32'h8;
    wait_cycles(2);
    sensor_data = model_board;
    wait_cycles(20);
    check("glitch_board", committed_board, 32'h0000_2DFF);
    check("glitch_quiet", {30'd0, move_valid, error}, 32'd0);

    sensor_data = model_board & ~32'h6;
    wait_cycles(12);
    check("dbl_lift_err", 32'(error), 32'd1);
    sensor_data = model_board;
    wait_cycles(12);
    check("restore_err", 32'(error), 32'd0);
    check("restore_board", committed_board, 32'h0000_2DFF);
    sensor_data = 32'h0010_0200;
    wait_cycles(12);
    check("new_board_err", 32'(error), 32'd1);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    check("resync_board", committed_board, 32'h0010_0200);
    check("resync_err", 32'(error), 32'd0);
    model_board = 32'h0010_0200;

    play_move(9, 18, 1'b1, 20, after);
    handshake(32'h0004_0000);

    do_resync(32'h0000_0FFF);
    for (int it = 0; it < 16; it++) begin
      b = model_board;
      if ($urandom_range(4, 0) == 0) begin
        f = pick(b, 1'b1);
        do a2 = pick(b, 1'b1); while (a2 == f);
        b[f] = 1'b0; b[a2] = 1'b0;
        sensor_data = b;
        wait_cycles(12);
        check("rnd_illegal_err", 32'(error), 32'd1);
        sensor_data = model_board;
        wait_cycles(12);
        check("rnd_recover_err", 32'(error), 32'd0);
        check("rnd_recover_board", committed_board, model_board);
      end else begin
        f = pick(b, 1'b1);
        t = pick(b, 1'b0);
        cap = ($urandom_range(1, 0) == 1) && ($countones(b) >= 4);
        c = 0;
        if (cap) do c = pick(b, 1'b1); while (c == f);
        play_move(f, t, cap, c, after);
        b[f] = 1'b0; b[t] = 1'b1;
        if (cap) b[c] = 1'b0;
        handshake(b);
        wait_cycles(12);
        check("rnd_after_quiet", {30'd0, move_valid, error}, 32'd0);
      end
    end

    b = model_board;
    f = pick(b, 1'b1);
    t = pick(b, 1'b0);
    play_move(f, t, 1'b0, 0, after);
    fields = {1'b1, 5'(f), 5'(t), 1'b0, 5'd0};
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 0) sensor_data = $urandom;
      @(negedge clk);
      check("emit_hold", 32'({move_valid, move_from, move_to, move_capture, capture_sq}),
            32'(fields));
    end
    sensor_data = after;
    wait_cycles(10);
    handshake(after);

    b = model_board;
    f = pick(b, 1'b1);
    t = pick(b, 1'b0);
    play_move(f, t, 1'b0, 0, after);
    reset = 1'b1;
    wait_cycles(2);
    check("rst_emit_valid", 32'(move_valid), 32'd0);
    check("rst_emit_board", committed_board, 32'd0);
    reset = 1'b0;
    wait_cycles(12);
    check("reinit_board", committed_board, after);
    check("reinit_quiet", {30'd0, move_valid, error}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
